// File: rtl/spu_pkg.sv
// Shared constants for the sprite/pixel unit: frame-buffer geometry, requester indices
// and arbiter state encoding.
package spu_pkg;

    localparam int unsigned FB_ADDR_W   = 17;
    localparam int unsigned FB_DATA_W   = 24;
    localparam int unsigned FRAME_WORDS = 76800;

    localparam int unsigned REQ_MAP     = 0;
    localparam int unsigned REQ_SPRITE  = 1;
    localparam int unsigned REQ_OVERLAY = 2;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 1'b0;
    localparam arb_state_t ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          valid
);

    localparam logic [PW:0] N_L = (PW + 1)'(N);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW + 1)'(k);
            if (sum >= N_L) begin
                sum = sum - N_L;
            end
            idx = sum[PW-1:0];
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_wr_arbiter.sv
// Round-robin, burst-bounded owner of the frame-buffer BRAM write port, with range
// checking and a per-frame accepted-write counter.
module frame_wr_arbiter
    import spu_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned ADDR_W      = FB_ADDR_W,
    parameter int unsigned DATA_W      = FB_DATA_W,
    parameter int unsigned MAX_BURST   = 64,
    parameter int unsigned FRAME_WORDS = 76800
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we_in,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    input  logic                      frame_clr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      fb_we,
    output logic [ADDR_W-1:0]         fb_addr,
    output logic [DATA_W-1:0]         fb_data,
    output logic                      oob_err,
    output logic                      busy,
    output logic [ADDR_W-1:0]         wr_count
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX    = BEAT_W'(MAX_BURST - 1);
    localparam logic [ADDR_W-1:0] FRAME_LIMIT = ADDR_W'(FRAME_WORDS);
    localparam logic [PTR_W-1:0]  LAST_REQ    = PTR_W'(NUM_REQ - 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]    holder_q, holder_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0]   fb_data_q, fb_data_d;
    logic                oob_q, oob_d;
    logic [ADDR_W-1:0]   wr_count_q, wr_count_d;

    logic [NUM_REQ-1:0]  pick;
    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W-1:0]    next_ptr;
    logic                hold_req;
    logic                hold_we;
    logic                others_pending;
    logic                accept;
    logic                in_range;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    // Only the holder's lanes are visible; gnt_q is one-hot in GRANT and zero in IDLE.
    always_comb begin
        pick_idx = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = PTR_W'(i);
            end
            if (gnt_q[i]) begin
                sel_addr = addr_in[i*ADDR_W +: ADDR_W];
                sel_data = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign hold_req       = |(req & gnt_q);
    assign hold_we        = |(we_in & gnt_q);
    assign others_pending = |(req & ~gnt_q);
    assign next_ptr       = (holder_q == LAST_REQ) ? '0 : holder_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        holder_d   = holder_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_GRANT;
                    gnt_d      = pick;
                    holder_d   = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (!hold_req || (beat_cnt_q == BEAT_MAX && others_pending)) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                end else if (beat_cnt_q != BEAT_MAX) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign accept   = (state_q == ST_GRANT) && hold_we;
    assign in_range = sel_addr < FRAME_LIMIT;

    always_comb begin
        fb_we_d   = accept && in_range;
        oob_d     = accept && !in_range;
        fb_addr_d = fb_we_d ? sel_addr : fb_addr_q;
        fb_data_d = fb_we_d ? sel_data : fb_data_q;
        // The counter tracks writes as they appear on the BRAM port.
        if (frame_clr) begin
            wr_count_d = ADDR_W'(fb_we_q);
        end else if (fb_we_q && wr_count_q != '1) begin
            wr_count_d = wr_count_q + 1'b1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            holder_q   <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            oob_q      <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            holder_q   <= holder_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            oob_q      <= oob_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign gnt      = gnt_q;
    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;
    assign oob_err  = oob_q;
    assign busy     = (state_q == ST_GRANT);
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_frame_wr_arbiter.sv
// Bench for frame_wr_arbiter: a rule-level model checked every cycle plus directed
// scenarios with literal expectations.
module tb_frame_wr_arbiter;

    localparam int AW = 17;
    localparam int DW = 24;
    localparam int NR = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    req;
    logic [2:0]    we_in;
    logic [50:0]   addr_in;
    logic [71:0]   data_in;
    logic          frame_clr;
    logic [2:0]    gnt;
    logic          fb_we;
    logic [16:0]   fb_addr;
    logic [23:0]   fb_data;
    logic          oob_err;
    logic          busy;
    logic [16:0]   wr_count;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    frame_wr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we_in     (we_in),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .frame_clr (frame_clr),
        .gnt       (gnt),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .oob_err   (oob_err),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: who holds the port, how long, where the pointer is, what the port shows.
    typedef struct {
        bit granted;
        int holder;
        int beats;
        int ptr;
        bit we;
        int addr;
        int data;
        bit oob;
        int count;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.granted = 0; r.holder = 0; r.beats = 0; r.ptr = 0;
        r.we = 0; r.addr = 0; r.data = 0; r.oob = 0; r.count = 0;
        return r;
    endfunction

    function automatic model_t step(model_t s, logic [2:0] rq, logic [2:0] we,
                                    logic [50:0] ad, logic [71:0] dt, logic clr);
        model_t n;
        bit     other;
        int     a;
        int     cand;
        n     = s;
        n.we  = 0;
        n.oob = 0;
        if (s.granted && we[s.holder]) begin
            a = int'(ad[s.holder*AW +: AW]);
            if (a < 76800) begin
                n.we   = 1;
                n.addr = a;
                n.data = int'(dt[s.holder*DW +: DW]);
            end else begin
                n.oob = 1;
            end
        end
        if (clr) n.count = s.we ? 1 : 0;
        else if (s.we && s.count < 131071) n.count = s.count + 1;
        if (s.granted) begin
            other = 0;
            for (int j = 0; j < NR; j++) if (j != s.holder && rq[j]) other = 1;
            if (!rq[s.holder] || (s.beats == 63 && other)) begin
                n.granted = 0;
                n.ptr     = (s.holder + 1) % NR;
            end else if (s.beats < 63) begin
                n.beats = s.beats + 1;
            end
        end else begin
            for (int k = NR - 1; k >= 0; k--) begin
                cand = (s.ptr + k) % NR;
                if (rq[cand]) begin
                    n.granted = 1;
                    n.holder  = cand;
                    n.beats   = 0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= step(m, req, we_in, addr_in, data_in, frame_clr);
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("m_gnt", {29'd0, gnt}, m.granted ? (32'd1 << m.holder) : 32'd0);
            chk("m_busy", {31'd0, busy}, {31'd0, m.granted});
            chk("m_fb_we", {31'd0, fb_we}, {31'd0, m.we});
            chk("m_fb_addr", {15'd0, fb_addr}, m.addr);
            chk("m_fb_data", {8'd0, fb_data}, m.data);
            chk("m_oob", {31'd0, oob_err}, {31'd0, m.oob});
            chk("m_count", {15'd0, wr_count}, m.count);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int i, input int a, input int d);
        addr_in[i*AW +: AW] = AW'(a);
        data_in[i*DW +: DW] = DW'(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; we_in = '0; frame_clr = 1'b0;
        addr_in = '0; data_in = '0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    int n;

    initial begin
        rst_n = 1'b0; req = '0; we_in = '0; frame_clr = 1'b0;
        addr_in = '0; data_in = '0;
        #2;
        chk("rst_gnt", {29'd0, gnt}, 0);
        chk("rst_fb_we", {31'd0, fb_we}, 0);
        chk("rst_count", {15'd0, wr_count}, 0);
        do_reset();
        cmp_en = 1'b1;

        // Single requester streaming ten writes.
        req = 3'b001; cyc();
        chk("t1_gnt", {29'd0, gnt}, 1);
        for (int i = 0; i < 10; i++) begin
            we_in = 3'b001; set_wr(0, i, 32'h100 + i); cyc();
        end
        we_in = '0; req = '0;
        cyc(); cyc(); cyc();
        chk("t1_count", {15'd0, wr_count}, 10);

        // Simultaneous requests out of reset.
        do_reset();
        req = 3'b101; cyc();
        chk("t2_first", {29'd0, gnt}, 1);
        repeat (4) cyc();
        req = 3'b100; cyc();
        chk("t2_idle", {29'd0, gnt}, 0);
        cyc();
        chk("t2_second", {29'd0, gnt}, 4);
        req = '0; cyc(); cyc();

        // Burst preemption.
        do_reset();
        req = 3'b010; cyc();
        n = 0;
        while (gnt === 3'b010 && n < 200) begin
            we_in = 3'b010; set_wr(1, 1000 + n, 32'h5000 + n);
            if (n == 10) req[0] = 1'b1;
            cyc();
            n++;
        end
        we_in = '0;
        chk("t3_burst_len", n, 64);
        chk("t3_drop", {29'd0, gnt}, 0);
        cyc();
        chk("t3_next", {29'd0, gnt}, 1);
        for (int k = 0; k < 3; k++) begin
            we_in = 3'b001; set_wr(0, 500 + k, 32'hA00 + k); cyc();
        end
        we_in = '0; req[0] = 1'b0; cyc();
        chk("t3_rel", {29'd0, gnt}, 0);
        cyc();
        chk("t3_regrant", {29'd0, gnt}, 2);
        req = '0; cyc(); cyc();

        // Range boundary.
        do_reset();
        req = 3'b001; cyc();
        we_in = 3'b001; set_wr(0, 76800, 32'h111111); cyc();
        chk("t4_oob", {31'd0, oob_err}, 1);
        chk("t4_oob_we", {31'd0, fb_we}, 0);
        set_wr(0, 76799, 32'h222222); cyc();
        chk("t4_ok_we", {31'd0, fb_we}, 1);
        chk("t4_ok_oob", {31'd0, oob_err}, 0);
        chk("t4_ok_addr", {15'd0, fb_addr}, 76799);
        we_in = '0; cyc(); cyc();
        chk("t4_count", {15'd0, wr_count}, 1);

        // Non-granted strobe is ignored.
        we_in = 3'b100; set_wr(2, 5, 32'h333333); cyc();
        set_wr(2, 90000, 32'h444444); cyc();
        chk("t5_we", {31'd0, fb_we}, 0);
        cyc();
        chk("t5_oob", {31'd0, oob_err}, 0);
        we_in = '0; req = '0; cyc(); cyc();

        // Reset mid-burst, pointer returns to 0.
        req = 3'b001; cyc(); req = '0; cyc(); cyc();
        req = 3'b010; cyc();
        for (int i = 0; i < 20; i++) begin
            we_in = 3'b010; set_wr(1, 2000 + i, 32'h700 + i); cyc();
        end
        rst_n = 1'b0; #1;
        chk("t6_rst_gnt", {29'd0, gnt}, 0);
        chk("t6_rst_we", {31'd0, fb_we}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_addr", {15'd0, fb_addr}, 0);
        req = '0; we_in = '0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_post_we", {31'd0, fb_we}, 0);
        chk("t6_post_count", {15'd0, wr_count}, 0);
        req = 3'b011; cyc();
        chk("t6_ptr0", {29'd0, gnt}, 1);
        for (int k = 0; k < 3; k++) begin
            we_in = 3'b001; set_wr(0, 100 + k, k); cyc();
        end
        we_in = '0; cyc(); cyc();
        chk("t6_count3", {15'd0, wr_count}, 3);
        we_in = 3'b001; set_wr(0, 200, 32'h999); cyc();
        we_in = '0; frame_clr = 1'b1; cyc();
        frame_clr = 1'b0;
        chk("t6_clr_write", {15'd0, wr_count}, 1);
        cyc();
        chk("t6_clr_hold", {15'd0, wr_count}, 1);
        req = '0; cyc(); cyc();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_wr_arbiter.md
Name: frame_wr_arbiter

Overview:
Owns the single write port of the 320x240 frame-buffer BRAM and shares it among NUM_REQ writers: draw_map, draw_sprite, and a future HUD overlay. Replaces the fixed enable-priority mux in the spu top level with a round-robin, burst-bounded grant scheme. Registers the winning write onto the BRAM port, drops out-of-range addresses, and counts accepted writes per frame for the spu controller.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = draw_map, 1 = draw_sprite, 2 = overlay)
ADDR_W, 17, frame-buffer address width
DATA_W, 24, pixel width (RGB888)
MAX_BURST, 64, granted cycles after which a holder is preempted if another requester is pending
FRAME_WORDS, 76800, valid address range is 0..FRAME_WORDS-1

Ports:
clk  in  1  100 MHz system clock (clk_100mhz_buf domain)
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester bus request, level, held until done
we_in  in  NUM_REQ  per-requester write strobe
addr_in  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
data_in  in  NUM_REQ*DATA_W  flattened write data, same packing
frame_clr  in  1  single-cycle pulse that clears wr_count
gnt  out  NUM_REQ  registered one-hot grant; all zero when idle
fb_we  out  1  frame-buffer write enable
fb_addr  out  ADDR_W  frame-buffer address
fb_data  out  DATA_W  frame-buffer data
oob_err  out  1  one-cycle pulse when a granted write is dropped for an address >= FRAME_WORDS
busy  out  1  high while state is GRANT
wr_count  out  ADDR_W  count of accepted writes since the last frame_clr; saturates at all-ones

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; gnt, fb_we, fb_addr, fb_data, oob_err, busy, wr_count and beat_cnt all 0; rr_ptr = 0. Reset mid-burst aborts the burst immediately and no pending write is issued afterwards.
- States are IDLE and GRANT.
- IDLE, any req high:
  - pick the first requester at or after rr_ptr, cyclic.
  - next cycle: gnt = onehot(pick), state = GRANT, beat_cnt = 0.
- IDLE, no req: gnt stays 0.
- GRANT, holder g:
  - we_in[g] is accepted only in a cycle where gnt[g] = 1.
  - next cycle: fb_we = 1 with the sampled addr/data, giving one cycle of latency.
  - we_in from non-granted requesters is ignored and has no side effects.
- GRANT, release (checked each cycle, first match wins):
  - req[g] = 0: gnt <= 0, state IDLE, rr_ptr <= g+1 mod NUM_REQ. A we_in[g] in that same cycle is still accepted.
  - beat_cnt = MAX_BURST-1 and some other req[j] = 1 (j != g): preempt; gnt <= 0, state IDLE, rr_ptr <= g+1 mod NUM_REQ. Holder g keeps req high and is re-arbitrated later.
  - otherwise: beat_cnt increments, saturating at MAX_BURST-1. If no other requester is pending, the holder keeps the grant indefinitely.
- There is always one IDLE cycle between grants. The requester sees gnt drop and must stall its writes until gnt returns.
- Range check: an accepted write with addr >= FRAME_WORDS gives fb_we = 0 and oob_err = 1 for one cycle; wr_count is unchanged.
- wr_count:
  - increments on every issued fb_we and saturates at 2^ADDR_W-1.
  - frame_clr sets it to 0.
  - frame_clr together with an issued write gives 1.
- fb_addr and fb_data hold their last values when fb_we = 0.
- Simultaneous requests: resolved purely by rr_ptr. Out of reset, req = 3'b101 grants requester 0.

Decomposition:
- Shared package spu_pkg: FB_ADDR_W = 17, FB_DATA_W = 24, FRAME_WORDS = 76800, requester index constants REQ_MAP/REQ_SPRITE/REQ_OVERLAY, arbiter state enum.
- One combinational sub-module, rr_pick (inputs req and ptr, output one-hot pick and valid), reused by a future ROM-read arbiter.

Test Plan:
- Reset, then req = 3'b001, we_in[0] for 10 cycles with addr 0..9 -> gnt = 001 one cycle after req; fb_we high 10 cycles, addresses 0..9 each one cycle after its we; wr_count = 10.
- req = 3'b101 out of reset, both hold req for 5 cycles -> requester 0 granted first; after req[0] drops, one IDLE cycle, then gnt = 100.
- Requester 1 writes continuously while requester 0 raises req at beat 10 -> preempt after 64 granted cycles; gnt goes 010, then 000, then 001; requester 1 re-granted after requester 0 releases.
- Granted write to addr 76800 and 76799 -> first gives oob_err pulse with no fb_we; second gives fb_we; wr_count +1 only.
- we_in[2] asserted without grant while requester 0 is granted -> no fb_we from requester 2 and no oob_err.
- rst_n asserted mid-burst after 20 writes, then released -> all outputs 0 and rr_ptr = 0; frame_clr coincident with a write gives wr_count = 1.
